// File: rtl/conf_int_add__result_acc.sv
// -----------------------------------------------------------------------------
// conf_int_add__result_acc
//
// Downstream stage of the 24-bit configurable (accurate/approximate) adder
// wrapper. The block registers each adder result and accumulates a window of
// 2^WINDOW_LOG2 results into a saturating unsigned sum. It also counts how many
// samples in the window came from the approximate path (acc__sel_in = 0).
// When the window closes, the block presents the sum, the approximate-sample
// count and a sticky overflow flag over a valid/ready handshake.
//
// Optional feature (macro CONF_INT_ADD_RESULT_ACC_FLUSH_EN):
//   Adds a `flush` input. Asserting flush closes a non-empty window early,
//   and the partial totals are presented on the outputs.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous, active-high reset
//   in_valid     in   d_in / acc__sel_in valid this cycle
//   in_ready     out  block accepts a sample this cycle (registered state only)
//   d_in         in   adder result, unsigned, IN_BITWIDTH bits
//   acc__sel_in  in   path select for this sample: 1 = accurate, 0 = approximate
//   flush        in   (macro only) close the current window early
//   out_valid    out  window result valid
//   out_ready    in   consumer accepts the result
//   sum_out      out  saturated unsigned window sum, ACC_BITWIDTH bits
//   apx_cnt_out  out  approximate-sample count in the window, WINDOW_LOG2+1 bits
//   ovf_out      out  accumulator saturated at least once in the window
// -----------------------------------------------------------------------------
module conf_int_add__result_acc #(
    parameter int IN_BITWIDTH  = 25,
    parameter int ACC_BITWIDTH = 32,
    parameter int WINDOW_LOG2  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_BITWIDTH-1:0]  d_in,
    input  logic                    acc__sel_in,
`ifdef CONF_INT_ADD_RESULT_ACC_FLUSH_EN
    input  logic                    flush,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_BITWIDTH-1:0] sum_out,
    output logic [WINDOW_LOG2:0]    apx_cnt_out,
    output logic                    ovf_out
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [WINDOW_LOG2-1:0] CNT_ONE  = 1;
    localparam logic [WINDOW_LOG2-1:0] CNT_LAST = '1;
    localparam logic [WINDOW_LOG2:0]   APX_ONE  = 1;

    // Saturating add. The MSB of the result flags saturation, and the lower
    // ACC_BITWIDTH bits hold the clamped sum.
    function automatic logic [ACC_BITWIDTH:0] sat_add(
        input logic [ACC_BITWIDTH-1:0] a,
        input logic [IN_BITWIDTH-1:0]  b
    );
        logic [ACC_BITWIDTH:0] s;
        s = {1'b0, a} + {{(ACC_BITWIDTH + 1 - IN_BITWIDTH){1'b0}}, b};
        if (s[ACC_BITWIDTH]) begin
            return {1'b1, {ACC_BITWIDTH{1'b1}}};
        end
        return s;
    endfunction

    logic [0:0]              state_q, state_d;
    logic [ACC_BITWIDTH-1:0] acc_q, acc_d;
    logic [WINDOW_LOG2-1:0]  cnt_q, cnt_d;
    logic [WINDOW_LOG2:0]    apx_q, apx_d;
    logic                    ovf_q, ovf_d;
    logic [ACC_BITWIDTH-1:0] sum_q, sum_d;
    logic [WINDOW_LOG2:0]    apx_out_q, apx_out_d;
    logic                    ovf_out_q, ovf_out_d;

    logic                    accept;
    logic                    flush_close;
    logic [ACC_BITWIDTH:0]   add_res;

    assign in_ready    = (state_q == ST_ACCUM);
    assign out_valid   = (state_q == ST_HOLD);
    assign sum_out     = sum_q;
    assign apx_cnt_out = apx_out_q;
    assign ovf_out     = ovf_out_q;

    assign accept = in_valid & in_ready;

    // An early close only applies to a non-empty window: either samples are
    // already held, or this cycle's beat is accepted together with the flush.
`ifdef CONF_INT_ADD_RESULT_ACC_FLUSH_EN
    assign flush_close = flush && (state_q == ST_ACCUM) && ((cnt_q != '0) || accept);
`else
    assign flush_close = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        apx_d     = apx_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        apx_out_d = apx_out_q;
        ovf_out_d = ovf_out_q;
        add_res   = sat_add(acc_q, d_in);

        if (state_q == ST_ACCUM) begin
            if (accept) begin
                acc_d = add_res[ACC_BITWIDTH-1:0];
                ovf_d = ovf_q | add_res[ACC_BITWIDTH];
                cnt_d = cnt_q + CNT_ONE;
                if (!acc__sel_in) begin
                    apx_d = apx_q + APX_ONE;
                end
            end
            // Outputs capture the post-update totals, so the closing beat is
            // included in the same edge.
            if ((accept && (cnt_q == CNT_LAST)) || flush_close) begin
                sum_d     = acc_d;
                apx_out_d = apx_d;
                ovf_out_d = ovf_d;
                state_d   = ST_HOLD;
            end
        end else if (out_ready) begin
            acc_d   = '0;
            cnt_d   = '0;
            apx_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            apx_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            apx_out_q <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            apx_q     <= apx_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            apx_out_q <= apx_out_d;
            ovf_out_q <= ovf_out_d;
        end
    end

endmodule
